// File: rtl/fetch_seq_ctrl.sv
// fetch_seq_ctrl
// Sequences the PC register and the instruction-fetch port of the single-issue core.
// One fetch is in flight at a time. The returned instruction is buffered for decode.
// The PC register is steered through its stall / branch / exception inputs.
// Redirects arriving while a fetch is outstanding are queued in pending registers.
// The response that was already in flight is then discarded.

module fetch_seq_ctrl #(
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  output logic        if_req_valid,
  output logic [31:0] if_req_addr,
  input  logic        if_req_ready,
  input  logic        if_rsp_valid,
  input  logic [31:0] if_rsp_data,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        br_req,
  input  logic [31:0] br_target,
  input  logic        exc_req,
  input  logic [31:0] exc_target,
  output logic        pc_stall,
  output logic        pc_branch_taken,
  output logic [31:0] pc_branch_target,
  output logic        pc_exc_redirect,
  output logic [31:0] pc_exc_target,
  output logic        fetch_err
);

  // Timeout threshold and saturation value of the 9-bit wait counter.
  localparam logic [8:0] TMO_LIMIT = 9'(TIMEOUT);
  localparam logic [8:0] TMO_MAX   = 9'h1FF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_REDIR = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic        pend_br_q, pend_br_d;
  logic        pend_exc_q, pend_exc_d;
  logic [31:0] br_tgt_q, br_tgt_d;
  logic [31:0] exc_tgt_q, exc_tgt_d;
  logic        kill_q, kill_d;
  logic [31:0] inst_data_q, inst_data_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [8:0]  tmo_cnt_q, tmo_cnt_d;
  logic        fetch_err_q, fetch_err_d;

  logic        redir_in_s;
  logic        pend_any_s;

  assign redir_in_s = br_req | exc_req;
  assign pend_any_s = pend_br_q | pend_exc_q;

  // Pending redirect capture: exc wins over br, newer targets overwrite older ones.
  always_comb begin
    pend_br_d  = pend_br_q;
    pend_exc_d = pend_exc_q;
    br_tgt_d   = br_tgt_q;
    exc_tgt_d  = exc_tgt_q;
    // The redirect cycle consumes whatever was pending.
    if (state_q == S_REDIR) begin
      pend_br_d  = 1'b0;
      pend_exc_d = 1'b0;
    end else begin
      pend_br_d  = pend_br_q;
      pend_exc_d = pend_exc_q;
    end
    // A same-cycle br is dropped in favour of exc; a br never touches the exc slot.
    if (exc_req) begin
      pend_exc_d = 1'b1;
      exc_tgt_d  = exc_target;
    end else if (br_req) begin
      pend_br_d  = 1'b1;
      br_tgt_d   = br_target;
    end else begin
      br_tgt_d   = br_tgt_q;
      exc_tgt_d  = exc_tgt_q;
    end
  end

  // Fetch sequencer: next state, buffer updates and all PC/fetch/decode outputs.
  always_comb begin
    state_d          = state_q;
    kill_d           = kill_q;
    inst_data_d      = inst_data_q;
    inst_pc_d        = inst_pc_q;
    if_req_valid     = 1'b0;
    if_req_addr      = 32'h0000_0000;
    inst_valid       = 1'b0;
    pc_stall         = 1'b1;
    pc_branch_taken  = 1'b0;
    pc_branch_target = 32'h0000_0000;
    pc_exc_redirect  = 1'b0;
    pc_exc_target    = 32'h0000_0000;
    case (state_q)
      S_IDLE: begin
        if (pend_any_s | redir_in_s) begin
          state_d = S_REDIR;
        end else begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // Address follows pc_in, which is held because pc_stall is asserted here.
        if_req_valid = 1'b1;
        if_req_addr  = pc_in;
        if (if_req_ready) begin
          state_d = S_WAIT;
          kill_d  = pend_any_s | redir_in_s;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (if_rsp_valid) begin
          kill_d = 1'b0;
          // The fetched word belongs to a PC about to be abandoned: drop it.
          if (kill_q | pend_any_s | redir_in_s) begin
            state_d = S_REDIR;
          end else begin
            inst_data_d = if_rsp_data;
            inst_pc_d   = pc_in;
            state_d     = S_HOLD;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_HOLD: begin
        // A redirect in the same cycle suppresses the handshake with decode.
        inst_valid = ~redir_in_s;
        if (redir_in_s) begin
          state_d = S_REDIR;
        end else if (inst_ready) begin
          pc_stall = 1'b0;
          state_d  = S_REQ;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_REDIR: begin
        pc_stall         = 1'b0;
        pc_exc_redirect  = pend_exc_q;
        pc_exc_target    = pend_exc_q ? exc_tgt_q : 32'h0000_0000;
        pc_branch_taken  = pend_br_q & ~pend_exc_q;
        pc_branch_target = (pend_br_q & ~pend_exc_q) ? br_tgt_q : 32'h0000_0000;
        if (redir_in_s) begin
          state_d = S_REDIR;
        end else begin
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Response timeout: saturating wait counter and sticky error flag.
  always_comb begin
    tmo_cnt_d   = 9'd0;
    fetch_err_d = fetch_err_q;
    if ((state_q == S_WAIT) && !if_rsp_valid) begin
      tmo_cnt_d = (tmo_cnt_q == TMO_MAX) ? TMO_MAX : (tmo_cnt_q + 9'd1);
    end else begin
      tmo_cnt_d = 9'd0;
    end
    // The FSM keeps waiting; the error only flags the condition.
    if ((state_q == S_WAIT) && (tmo_cnt_q >= TMO_LIMIT)) begin
      fetch_err_d = 1'b1;
    end else begin
      fetch_err_d = fetch_err_q;
    end
  end

  // State and data registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pend_br_q   <= 1'b0;
      pend_exc_q  <= 1'b0;
      br_tgt_q    <= 32'h0000_0000;
      exc_tgt_q   <= 32'h0000_0000;
      kill_q      <= 1'b0;
      inst_data_q <= 32'h0000_0000;
      inst_pc_q   <= 32'h0000_0000;
      tmo_cnt_q   <= 9'd0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_br_q   <= pend_br_d;
      pend_exc_q  <= pend_exc_d;
      br_tgt_q    <= br_tgt_d;
      exc_tgt_q   <= exc_tgt_d;
      kill_q      <= kill_d;
      inst_data_q <= inst_data_d;
      inst_pc_q   <= inst_pc_d;
      tmo_cnt_q   <= tmo_cnt_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign inst_data = inst_data_q;
  assign inst_pc   = inst_pc_q;
  assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Bench for fetch_seq_ctrl.
// The bench plays the PC register and the instruction memory.
// A behavioural model keeps redirects as an ordered list and predicts every output each cycle.
// Directed scenarios are followed by randomized traffic.

module tb_fetch_seq_ctrl;

  localparam int TIMEOUT = 256;
  localparam int P_IDLE = 0, P_REQ = 1, P_WAIT = 2, P_HOLD = 3, P_REDIR = 4;

  logic        clk, rst;
  logic [31:0] pc_in;
  logic        if_req_valid;
  logic [31:0] if_req_addr;
  logic        if_req_ready, if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        inst_valid;
  logic [31:0] inst_data, inst_pc;
  logic        inst_ready, br_req, exc_req;
  logic [31:0] br_target, exc_target;
  logic        pc_stall, pc_branch_taken, pc_exc_redirect, fetch_err;
  logic [31:0] pc_branch_target, pc_exc_target;

  fetch_seq_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .br_req(br_req), .br_target(br_target), .exc_req(exc_req), .exc_target(exc_target),
    .pc_stall(pc_stall), .pc_branch_taken(pc_branch_taken), .pc_branch_target(pc_branch_target),
    .pc_exc_redirect(pc_exc_redirect), .pc_exc_target(pc_exc_target), .fetch_err(fetch_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct { int due; logic [31:0] data; } mem_t;
  typedef struct { bit exc; logic [31:0] tgt; } redir_t;

  mem_t   mem_q[$];
  redir_t rq[$];

  int n_total = 0, n_bad = 0, cyc = 0;
  int m_ph = P_IDLE, m_wcnt = 0;
  bit m_err = 1'b0;
  logic [31:0] m_pc = 32'h8000_0000, m_idata = 32'h0, m_ipc = 32'h0;
  bit fixed_en = 1'b0, spur_en = 1'b0;

  // last sampled DUT outputs, for scenario-level checks
  logic [31:0] s_addr, s_ipc, s_idata, s_btgt, s_etgt;
  logic        s_stall, s_bt, s_ex, s_err, s_iv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs at negedge, compare with model, advance model.
  task automatic step(input bit r, input bit br, input logic [31:0] bt, input bit ex,
                      input logic [31:0] et, input bit rdy, input bit irdy, input int lat);
    bit          rv, have_exc, have_br, e_reqv, e_iv, e_stall, e_bt, e_ex, newr;
    logic [31:0] rd, last_exc, last_br, e_addr, e_btgt, e_etgt;
    mem_t        m;
    @(negedge clk);
    cyc++;
    rv = 1'b0;
    rd = $urandom();
    for (int i = 0; i < mem_q.size(); i++) begin
      if (mem_q[i].due <= cyc) begin
        rv = 1'b1;
        rd = mem_q[i].data;
        mem_q.delete(i);
        break;
      end
    end
    if (!rv && spur_en && (m_ph != P_WAIT) && ($urandom_range(0, 7) == 0)) rv = 1'b1;
    rst = r; pc_in = m_pc; if_req_ready = rdy; if_rsp_valid = rv; if_rsp_data = rd;
    inst_ready = irdy; br_req = br; br_target = bt; exc_req = ex; exc_target = et;
    #1;
    // resolve pending redirects: any exc beats br, most recent target of each kind wins
    have_exc = 1'b0; have_br = 1'b0; last_exc = 32'h0; last_br = 32'h0;
    foreach (rq[i]) begin
      if (rq[i].exc) begin have_exc = 1'b1; last_exc = rq[i].tgt; end
      else begin have_br = 1'b1; last_br = rq[i].tgt; end
    end
    newr    = br | ex;
    e_reqv  = (m_ph == P_REQ);
    e_addr  = e_reqv ? m_pc : 32'h0;
    e_iv    = (m_ph == P_HOLD) && !newr;
    e_stall = !((m_ph == P_REDIR) || (e_iv && irdy));
    e_ex    = (m_ph == P_REDIR) && have_exc;
    e_etgt  = e_ex ? last_exc : 32'h0;
    e_bt    = (m_ph == P_REDIR) && have_br && !have_exc;
    e_btgt  = e_bt ? last_br : 32'h0;
    chk("req_valid",  32'(if_req_valid),    32'(e_reqv));
    chk("req_addr",   if_req_addr,          e_addr);
    chk("inst_valid", 32'(inst_valid),      32'(e_iv));
    chk("inst_data",  inst_data,            m_idata);
    chk("inst_pc",    inst_pc,              m_ipc);
    chk("pc_stall",   32'(pc_stall),        32'(e_stall));
    chk("br_taken",   32'(pc_branch_taken), 32'(e_bt));
    chk("br_target",  pc_branch_target,     e_btgt);
    chk("exc_redir",  32'(pc_exc_redirect), 32'(e_ex));
    chk("exc_target", pc_exc_target,        e_etgt);
    chk("fetch_err",  32'(fetch_err),       32'(m_err));
    s_addr = if_req_addr; s_ipc = inst_pc; s_idata = inst_data; s_stall = pc_stall;
    s_bt = pc_branch_taken; s_btgt = pc_branch_target; s_ex = pc_exc_redirect;
    s_etgt = pc_exc_target; s_err = fetch_err; s_iv = inst_valid;
    // memory accepts the request
    if (e_reqv && rdy) begin
      m.due  = cyc + lat;
      m.data = fixed_en ? 32'h0000_0013 : $urandom();
      mem_q.push_back(m);
    end
    if (r) begin
      m_ph = P_IDLE; rq.delete(); m_idata = 32'h0; m_ipc = 32'h0;
      m_err = 1'b0; m_wcnt = 0; m_pc = 32'h8000_0000;
    end else begin
      // PC register reacts to the expected steering
      if (!e_stall) m_pc = e_ex ? last_exc : (e_bt ? last_br : m_pc + 32'd4);
      if (m_ph == P_REDIR) rq.delete();
      if (ex) rq.push_back('{1'b1, et});
      else if (br) rq.push_back('{1'b0, bt});
      if (m_ph == P_WAIT) begin
        if (m_wcnt >= TIMEOUT) m_err = 1'b1;
        m_wcnt = rv ? 0 : m_wcnt + 1;
      end else begin
        m_wcnt = 0;
      end
      case (m_ph)
        P_IDLE:  m_ph = (rq.size() != 0) ? P_REDIR : P_REQ;
        P_REQ:   if (rdy) m_ph = P_WAIT;
        P_WAIT:  if (rv) begin
                   if (rq.size() != 0) m_ph = P_REDIR;
                   else begin m_idata = rd; m_ipc = pc_in; m_ph = P_HOLD; end
                 end
        P_HOLD:  if (newr) m_ph = P_REDIR; else if (irdy) m_ph = P_REQ;
        default: m_ph = newr ? P_REDIR : P_REQ;
      endcase
    end
  endtask

  task automatic quiet_step();
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1);
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < 40 && m_ph != target; i++) quiet_step();
    chk("run_to_phase", 32'(m_ph), 32'(target));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pc_in = 32'h8000_0000; if_req_ready = 1'b0; if_rsp_valid = 1'b0;
    if_rsp_data = 32'h0; inst_ready = 1'b0; br_req = 1'b0; br_target = 32'h0;
    exc_req = 1'b0; exc_target = 32'h0;
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1);
    chk("rst_stall", 32'(s_stall), 32'd1);

    // 1: basic fetch of 0x13 at reset PC, accept, next request at +4
    fixed_en = 1'b1;
    run_to(P_HOLD);
    quiet_step();
    chk("t1_ipc", s_ipc, 32'h8000_0000);
    chk("t1_data", s_idata, 32'h0000_0013);
    chk("t1_stall", 32'(s_stall), 32'd0);
    quiet_step();
    chk("t1_next_addr", s_addr, 32'h8000_0004);
    fixed_en = 1'b0;

    // 2: branch while waiting for the response
    run_to(P_REQ);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 3);
    step(1'b0, 1'b1, 32'h8000_0100, 1'b0, 32'h0, 1'b1, 1'b1, 1);
    run_to(P_REDIR);
    quiet_step();
    chk("t2_taken", 32'(s_bt), 32'd1);
    chk("t2_target", s_btgt, 32'h8000_0100);
    chk("t2_no_exc", 32'(s_ex), 32'd0);

    // 3: simultaneous br and exc while request is stalled
    run_to(P_REQ);
    step(1'b0, 1'b1, 32'h8000_0100, 1'b1, 32'h8000_0200, 1'b0, 1'b1, 1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 2);
    run_to(P_REDIR);
    quiet_step();
    chk("t3_exc", 32'(s_ex), 32'd1);
    chk("t3_exc_target", s_etgt, 32'h8000_0200);
    chk("t3_no_br", 32'(s_bt), 32'd0);

    // 4: decode stalls for 5 cycles
    run_to(P_HOLD);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1);
      chk("t4_stall_held", 32'(s_stall), 32'd1);
    end
    quiet_step();
    chk("t4_accept", 32'(s_stall), 32'd0);

    // 5: response withheld past TIMEOUT, then a late response
    run_to(P_REQ);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 300);
    for (int i = 0; i < 300; i++) quiet_step();
    chk("t5_err", 32'(s_err), 32'd1);
    quiet_step();
    chk("t5_late_accept", 32'(s_iv), 32'd1);
    for (int i = 0; i < 4; i++) quiet_step();
    chk("t5_err_sticky", 32'(s_err), 32'd1);

    // 6: reset while waiting, response lands after reset
    run_to(P_REQ);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 2);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1);
    quiet_step();
    quiet_step();
    chk("t6_addr", s_addr, 32'h8000_0000);
    chk("t6_err_clr", 32'(s_err), 32'd0);

    // randomized traffic
    spur_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      bit r, b, e;
      r = ($urandom_range(0, 499) == 0);
      b = !r && ($urandom_range(0, 11) == 0);
      e = !r && ($urandom_range(0, 24) == 0);
      step(r, b, $urandom() & 32'hFFFF_FFFC, e, $urandom() & 32'hFFFF_FFFC,
           $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, $urandom_range(1, 4));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
